pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register that replaces the hand-built per-stage register banks (IF/ID, ID/EX, EX/ME, ME/WB).
- Carries a DATA_W payload and a CTRL_W control bundle between two processor stages.
- Adds a valid/ready handshake, a hold input (stall), a squash input (flush), bubble insertion on the control bundle, and saturating stall/bubble performance counters.
- An optional skid entry decouples in_ready from out_ready timing.

---
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline-stage register with hold, squash, bubble and perf counters
//
// Purpose:
//   Carries a DATA_W payload and CTRL_W control bundle between two processor
//   stages with a valid/ready handshake. stall freezes the stage, flush kills
//   every held entry, and out_ctrl reads CTRL_BUBBLE whenever nothing is live.
//   Optional feature macro: PIPE_STAGE_SKID_EN (adds a second, skid entry and
//   turns in_ready into a register).
//
// Ports:
//   clk, rst             stage clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake
//   in_data, in_ctrl     upstream payload and control bundle
//   stall, flush         hazard-unit hold and squash
//   out_valid/out_ready  downstream handshake
//   out_data, out_ctrl   held payload; held control or CTRL_BUBBLE
//   occupancy            live entries held
//   stall_cnt            saturating count of edges with stall=1
//   bubble_cnt           saturating count of edges with out_valid=0
module pipe_stage_reg #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              drain;

  // Downstream consumes the main entry at this edge.
  assign drain = main_v && out_ready && !stall && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v;
  logic              skid_v_nxt;
  logic              in_ready_q;
  logic              accept;
  logic              main_take;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign accept    = in_valid && in_ready_q;
  // Main slot is free to be written at this edge.
  assign main_take = !main_v || drain;

  always_comb begin
    skid_v_nxt = skid_v;
    if (flush || main_take) begin
      skid_v_nxt = 1'b0;
    end else if (accept) begin
      skid_v_nxt = 1'b1;
    end
  end

  // A beat handshaken while in_ready was still high is kept even if stall
  // rises in the same cycle: the held entries freeze, the new beat lands in
  // the first free slot, and in_ready drops on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v    <= 1'b0;
      main_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
    end else if (flush) begin
      main_v <= 1'b0;
    end else if (main_take) begin
      if (skid_v) begin
        main_v    <= 1'b1;
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (accept) begin
        main_v    <= 1'b1;
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else begin
        main_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_v     <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= CTRL_BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      skid_v     <= skid_v_nxt;
      in_ready_q <= !skid_v_nxt && !stall && !flush;
      if (!flush && !main_take && accept) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
  logic load;

  assign in_ready = !stall && !flush && (!main_v || out_ready);
  assign load     = in_valid && in_ready;

  // in_ready already excludes stall and flush, so load never fights them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v    <= 1'b0;
      main_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
    end else if (flush) begin
      main_v <= 1'b0;
    end else if (load) begin
      main_v    <= 1'b1;
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (drain) begin
      main_v <= 1'b0;
    end
  end

  assign occupancy = {1'b0, main_v};
`endif

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_v ? main_ctrl : CTRL_BUBBLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!main_v && bubble_cnt != CNT_MAX) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard testbench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;
  logic [15:0]   bubble_cnt;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [DW-1:0] sat_out_data;
  logic [CW-1:0] sat_out_ctrl;
  logic [1:0]    sat_occupancy;
  logic [3:0]    sat_stall_cnt;
  logic [3:0]    sat_bubble_cnt;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries are {ctrl, data}.
  logic [DW+CW-1:0] sbq[$];
  logic [DW+CW-1:0] exp_beat;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_ctrl(sat_out_ctrl), .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt),
    .bubble_cnt(sat_bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    sbq.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h3C;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55 || out_ctrl !== 8'h3C) begin
      errors++;
      $display("FAIL reset_preload: got v=%0b d=%h c=%h want v=1 d=55 c=3c", out_valid, out_data, out_ctrl);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b c=%h d=%h occ=%0d want v=0 c=00 d=0 occ=0", out_valid, out_ctrl, out_data, occupancy);
    end
    checks++;
    if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt);
    end
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h01;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || out_ctrl !== 8'h01) begin
      errors++;
      $display("FAIL reset_first_load: got v=%0b d=%h c=%h want v=1 d=77 c=01", out_valid, out_data, out_ctrl);
    end
    checks++;
    if (bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_first_bubble: got %0d want 1", bubble_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vals [4];
    vals[0] = 32'h10; vals[1] = 32'h14; vals[2] = 32'h18; vals[3] = 32'h1C;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      in_ctrl  = 8'(i + 1);
      sbq.push_back({in_ctrl, in_data});
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready);
      end
      // Beat loaded on the previous edge is being consumed on this one.
      if (i > 0) begin
        exp_beat = sbq.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_ctrl, out_data} !== exp_beat) begin
          errors++;
          $display("FAIL stream_out[%0d]: got v=%0b %h want %h", i - 1, out_valid, {out_ctrl, out_data}, exp_beat);
        end
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_beat = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_ctrl, out_data} !== exp_beat) begin
      errors++;
      $display("FAIL stream_out[3]: got v=%0b %h want %h", out_valid, {out_ctrl, out_data}, exp_beat);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stream_end: got v=%0b c=%h bubble=%0d want v=0 c=00 bubble=1", out_valid, out_ctrl, bubble_cnt);
    end
  endtask

`ifndef PIPE_STAGE_SKID_EN
  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1; in_data = 32'hAA; in_ctrl = 8'h11;
    sbq.push_back({in_ctrl, in_data});
    step();
    in_data = 32'hBB; in_ctrl = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_ctrl, out_data} !== sbq[0]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b %h want rdy=0 v=1 %h", i, in_ready, out_valid, {out_ctrl, out_data}, sbq[0]);
      end
      step();
    end
    out_ready = 1'b1;
    sbq.push_back({in_ctrl, in_data});
    @(negedge clk);
    exp_beat = sbq.pop_front();
    checks++;
    if (in_ready !== 1'b1 || {out_ctrl, out_data} !== exp_beat) begin
      errors++;
      $display("FAIL bp_release: got rdy=%0b %h want rdy=1 %h", in_ready, {out_ctrl, out_data}, exp_beat);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    exp_beat = sbq.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_ctrl, out_data} !== exp_beat) begin
      errors++;
      $display("FAIL bp_next: got v=%0b %h want %h", out_valid, {out_ctrl, out_data}, exp_beat);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: got v=%0b want 0", out_valid);
    end
  endtask
`endif

  task automatic test_stall_flush();
    do_reset();
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h44;
    step();
    in_valid  = 1'b0;
    stall     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h33 || out_ctrl !== 8'h44) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%0b d=%h c=%h want v=1 d=33 c=44", i, out_valid, out_data, out_ctrl);
      end
`ifndef PIPE_STAGE_SKID_EN
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready);
      end
`endif
      step();
    end
    checks++;
    if (stall_cnt !== 16'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_cnt: got cnt=%0d v=%0b want cnt=5 v=1", stall_cnt, out_valid);
    end
    flush = 1'b1;
    in_valid = 1'b1; in_data = 32'h66;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %0b want 0", in_ready);
    end
    step();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 || stall_cnt !== 16'd6) begin
      errors++;
      $display("FAIL flush_result: got v=%0b c=%h occ=%0d stall=%0d want v=0 c=00 occ=0 stall=6", out_valid, out_ctrl, occupancy, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) begin
        checks++;
        if (sat_stall_cnt !== 4'd15) begin
          errors++;
          $display("FAIL sat_reach: got %0d want 15", sat_stall_cnt);
        end
      end
    end
    stall = 1'b0;
    checks++;
    if (sat_stall_cnt !== 4'd15 || sat_bubble_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_stick: got stall=%0d bubble=%0d want 15 15", sat_stall_cnt, sat_bubble_cnt);
    end
    checks++;
    if (stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_wide: got %0d want 20", stall_cnt);
    end
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_skid();
    do_reset();
    in_valid = 1'b1; in_data = 32'h1; in_ctrl = 8'h01;
    sbq.push_back({in_ctrl, in_data});
    step();
    in_data = 32'h2; in_ctrl = 8'h02;
    sbq.push_back({in_ctrl, in_data});
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL skid_full: got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_beat = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_ctrl, out_data} !== exp_beat) begin
        errors++;
        $display("FAIL skid_order[%0d]: got v=%0b %h want %h", i, out_valid, {out_ctrl, out_data}, exp_beat);
      end
      step();
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h3;
    step();
    in_data = 32'h4;
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL skid_refill: got occ=%0d want 2", occupancy);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_flush: got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
`ifndef PIPE_STAGE_SKID_EN
    test_backpressure();
`endif
    test_stall_flush();
    test_saturation();
`ifdef PIPE_STAGE_SKID_EN
    test_skid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
